// File: rtl/div_32_pkg.sv
// Shared definitions for the iterative signed divider: state encoding,
// iteration count and the magnitude helper used at operand capture.
package div_32_pkg;

    localparam int          DIV_ITER = 32;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // INT_MIN maps onto itself, which is the correct magnitude read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_32_step.sv
// One restoring shift-subtract iteration on the {R,Q} working register.
module div_step (
    input  logic [63:0] rq_in,
    input  logic [31:0] divisor,
    output logic [63:0] rq_out
);

    logic [63:0] shifted;
    logic [32:0] trial;

    always_comb begin
        shifted = {rq_in[62:0], 1'b0};
        // The bit shifted out of R becomes the 33rd bit of the trial difference.
        trial   = {rq_in[63], shifted[63:32]} - {1'b0, divisor};
        if (!trial[32]) begin
            rq_out = {trial[31:0], shifted[31:1], 1'b1};
        end else begin
            rq_out = {shifted[63:1], 1'b0};
        end
    end

endmodule

// File: rtl/div_32.sv
// Multicycle 32-bit signed divider: sign/magnitude capture, 32 restoring
// iterations, a sign/overflow fix cycle and a one-cycle ready pulse.
// Handshake: ctrl_DIV is a one-cycle start pulse accepted in any state (it
// aborts a running divide); data_resultRDY pulses once per completed divide,
// with data_result/data_exception valid from that cycle until the next one.
module div_32
    import div_32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output div_state_t       dbg_state
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

    div_state_t  state, state_next;
    logic [4:0]  count;
    logic [63:0] rq, rq_next;
    logic [31:0] abs_b, op_a, op_b;
    logic        sign;
    logic        div_zero;
    logic [31:0] quotient;
    logic        overflow;

    div_step u_step (
        .rq_in  (rq),
        .divisor(abs_b),
        .rq_out (rq_next)
    );

    assign div_zero = (data_operandB == 32'd0);
    assign quotient = sign ? (~rq[31:0] + 32'd1) : rq[31:0];
    assign overflow = (op_a == INT_MIN) && (op_b == 32'hFFFF_FFFF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        data_resultRDY = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: state_next = IDLE;
            RUN: begin
                busy = 1'b1;
                if (count == LAST_ITER) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                data_resultRDY = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A start request wins from every state, including an abort of RUN/FIX.
        if (ctrl_DIV) state_next = div_zero ? DONE : RUN;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count          <= 5'd0;
            rq             <= 64'd0;
            abs_b          <= 32'd0;
            op_a           <= 32'd0;
            op_b           <= 32'd0;
            sign           <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else if (ctrl_DIV) begin
            sign  <= data_operandA[31] ^ data_operandB[31];
            abs_b <= abs32(data_operandB);
            op_a  <= data_operandA;
            op_b  <= data_operandB;
            rq    <= {32'd0, abs32(data_operandA)};
            count <= 5'd0;
            if (div_zero) begin
                data_result    <= 32'd0;
                data_exception <= 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    rq    <= rq_next;
                    count <= count + 5'd1;
                end
                FIX: begin
                    data_result    <= overflow ? INT_MIN : quotient;
                    data_exception <= overflow;
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_div_32.sv
// Self-checking bench for div_32: directed and random divides against a
// plain signed-arithmetic model, checked by a queue-driven monitor.
module tb_div_32;
    import div_32_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    div_state_t  dbg_state;

    div_32 #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic        exc_q[$];
    int          cyc_q[$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed division truncating toward zero, with the two
    // exceptional cases defined for the divider.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return {1'b1, INT_MIN};
        q = 32'($signed(a) / $signed(b));
        return {1'b0, q};
    endfunction

    // ---------------- driver tasks ----------------
    // Caller is positioned at a negedge; the start is sampled at the next posedge.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b, input bit abort);
        logic [32:0] r;
        int c0;
        c0 = cyc;
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        if (abort && exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            void'(exc_q.pop_back());
            void'(cyc_q.pop_back());
        end
        r = ref_div(a, b);
        exp_q.push_back(r[31:0]);
        exc_q.push_back(r[32]);
        cyc_q.push_back(c0 + ((b == 32'd0) ? 1 : 34));
        @(posedge clock);
        #1 ctrl_DIV = 1'b0;
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (data_resultRDY) break;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rdy: got ready pulse with result %h, required no pulse (cycle %0d)",
                         data_result, cyc);
            end else begin
                check("result", data_result, exp_q.pop_front());
                check("exception", {31'd0, data_exception}, {31'd0, exc_q.pop_front()});
                check("rdy_cycle", cyc, cyc_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    int          busy_err;
    int          busy_seen;
    logic [31:0] ra, rb;
    int          sel;

    initial begin
        repeat (2) @(negedge clock);
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
        reset = 1'b0;
        @(negedge clock);

        // 7/2 with busy profile across cycles 1..34
        start_div(32'd7, 32'd2, 0);
        busy_err = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock);
            if (busy !== (k <= 33)) busy_err++;
        end
        check("busy_window_errs", busy_err, 0);
        repeat (3) @(negedge clock);
        check("hold_in_idle", data_result, 32'd3);

        // signed combinations, back to back
        start_div(32'hFFFF_FFF9, 32'd2, 0);          wait_rdy();
        start_div(32'd7, 32'hFFFF_FFFE, 0);          wait_rdy();
        start_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);  wait_rdy();

        // divide by zero: ready in cycle 1, busy never high
        start_div(32'd5, 32'd0, 0);
        busy_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (busy) busy_seen++;
        end
        check("div0_busy", busy_seen, 0);

        start_div(INT_MIN, 32'hFFFF_FFFF, 0);        wait_rdy();
        start_div(INT_MIN, 32'd2, 0);                wait_rdy();

        // result stays stable through a following RUN
        start_div(32'd5, 32'd1, 0);
        repeat (9) @(negedge clock);
        check("hold_in_run", data_result, 32'hC000_0000);
        wait_rdy();

        // abort in cycle 10
        @(negedge clock);
        start_div(32'd1000, 32'd3, 0);
        repeat (10) @(negedge clock);
        start_div(32'd100, 32'd7, 1);
        wait_rdy();

        // reset in cycle 20 of a run
        @(negedge clock);
        start_div(32'd50, 32'd5, 0);
        repeat (19) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        exp_q.delete();
        exc_q.delete();
        cyc_q.delete();
        #1;
        check("rst_mid_result", data_result, 32'd0);
        check("rst_mid_exc", {31'd0, data_exception}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_state", {30'd0, dbg_state}, {30'd0, IDLE});
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        start_div(32'd50, 32'd5, 0);
        wait_rdy();

        // randomized divides with mixed gaps (gap 0 restarts in the DONE cycle)
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = 32'($signed($urandom) >>> $urandom_range(0, 31));
            if (sel == 0) rb = 32'd0;
            if (sel == 1) rb = 32'hFFFF_FFFF;
            if (sel == 2) ra = INT_MIN;
            if (sel == 1 && ($urandom_range(0, 1) == 1)) ra = INT_MIN;
            start_div(ra, rb, 0);
            wait_rdy();
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
